// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon host block receiver.
//   ASCON_W        : block width in bits
//   phase_t        : message phase seen by the host-side receiver
//   TAG_*_OFS      : tag bit offsets above the data field of an input FIFO
//                    entry laid out as {last, is_text, data}
//   RES_LAST_OFS   : tag bit offset above the data field of an output FIFO
//                    entry laid out as {last, data}
package ascon_pkg;

    localparam int ASCON_W      = 128;

    localparam int TAG_TEXT_OFS = 0;
    localparam int TAG_LAST_OFS = 1;
    localparam int RES_LAST_OFS = 0;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_AD    = 2'd1,
        PH_TEXT  = 2'd2,
        PH_DRAIN = 2'd3
    } phase_t;

endpackage

// File: rtl/ascon_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
//   clk, rstn     : clock, asynchronous active-low reset
//   push, wdata   : write request and data (dropped when full unless popping)
//   pop           : read request, advances the head (ignored when empty)
//   rdata         : head entry, combinational
//   full, empty   : occupancy flags
// DEPTH must be a power of two, at least 2.
module ascon_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    // Pointers wrap modulo 2*DEPTH; the extra MSB separates full from empty.
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign rd_en_s = pop & ~empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign wr_en_s = push & (~full | rd_en_s);
    assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ascon_blk_rx.sv
// Core-side responder for the Ascon host block interface.
//   Host input : start, Din/dinReq/sel_data/last_block -> dinAck (four-phase)
//   Host output: Dout/doReq <- doAck
//   Status     : busy, finished (one-cycle pulse), proto_err (sticky)
//   Engine in  : blk_data/blk_is_text/blk_last/blk_valid <- blk_ready
//   Engine out : res_data/res_last/res_valid -> res_ready
// Host blocks are tagged and queued in the input FIFO; engine results are
// queued in the output FIFO and handed back to the host.
module ascon_blk_rx
    import ascon_pkg::*;
#(
    parameter int W         = ASCON_W,
    parameter int IN_DEPTH  = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [W-1:0] Din,
    input  logic         dinReq,
    input  logic         sel_data,
    input  logic         last_block,
    output logic         dinAck,
    output logic [W-1:0] Dout,
    output logic         doReq,
    input  logic         doAck,
    output logic         busy,
    output logic         finished,
    output logic         proto_err,
    output logic [W-1:0] blk_data,
    output logic         blk_is_text,
    output logic         blk_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    input  logic [W-1:0] res_data,
    input  logic         res_last,
    input  logic         res_valid,
    output logic         res_ready
);

    phase_t       phase_r, phase_nxt_s;
    logic         armed_r, armed_nxt_s;
    logic         din_ack_r;
    logic         busy_r, busy_nxt_s;
    logic         finished_r, finished_nxt_s;
    logic         proto_err_r, proto_err_nxt_s;

    logic         capture_s;
    logic         order_err_s;
    logic         in_pop_s, in_full_s, in_empty_s;
    logic [W+1:0] in_wdata_s, in_rdata_s;
    logic         out_push_s, out_pop_s, out_full_s, out_empty_s;
    logic [W:0]   out_wdata_s, out_rdata_s;
    logic         out_head_last_s;

    // A block is taken only once per dinReq assertion, only while a message
    // is accepting data, and only when the input FIFO has room.
    assign capture_s   = dinReq & armed_r & ~in_full_s &
                         ((phase_r == PH_AD) | (phase_r == PH_TEXT));
    assign order_err_s = capture_s & (phase_r == PH_TEXT) & ~sel_data;

    assign in_wdata_s  = {last_block, sel_data, Din};
    assign in_pop_s    = ~in_empty_s & blk_ready;

    ascon_sync_fifo #(.WIDTH(W+2), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (capture_s),
        .pop   (in_pop_s),
        .wdata (in_wdata_s),
        .rdata (in_rdata_s),
        .full  (in_full_s),
        .empty (in_empty_s)
    );

    assign blk_valid   = ~in_empty_s;
    assign blk_data    = in_rdata_s[W-1:0];
    assign blk_is_text = in_rdata_s[W+TAG_TEXT_OFS];
    assign blk_last    = in_rdata_s[W+TAG_LAST_OFS];

    assign res_ready   = ~out_full_s;
    assign out_push_s  = res_valid & ~out_full_s;
    assign out_wdata_s = {res_last, res_data};
    assign out_pop_s   = ~out_empty_s & doAck;

    ascon_sync_fifo #(.WIDTH(W+1), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (out_push_s),
        .pop   (out_pop_s),
        .wdata (out_wdata_s),
        .rdata (out_rdata_s),
        .full  (out_full_s),
        .empty (out_empty_s)
    );

    assign doReq           = ~out_empty_s;
    // Stale storage is masked so the host sees zero when nothing is pending.
    assign Dout            = out_empty_s ? {W{1'b0}} : out_rdata_s[W-1:0];
    assign out_head_last_s = out_rdata_s[W+RES_LAST_OFS];

    assign dinAck    = din_ack_r;
    assign busy      = busy_r;
    assign finished  = finished_r;
    assign proto_err = proto_err_r;

    // Phase, handshake and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_r     <= PH_IDLE;
            armed_r     <= 1'b1;
            din_ack_r   <= 1'b0;
            busy_r      <= 1'b0;
            finished_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            phase_r     <= phase_nxt_s;
            armed_r     <= armed_nxt_s;
            din_ack_r   <= capture_s;
            busy_r      <= busy_nxt_s;
            finished_r  <= finished_nxt_s;
            proto_err_r <= proto_err_nxt_s;
        end
    end

    // Next-state logic for phase, arming and status.
    always_comb begin
        phase_nxt_s     = phase_r;
        busy_nxt_s      = busy_r;
        finished_nxt_s  = 1'b0;
        proto_err_nxt_s = proto_err_r;
        armed_nxt_s     = armed_r;

        // Re-arm only after the host has dropped its request.
        if (capture_s) begin
            armed_nxt_s = 1'b0;
        end else if (!dinReq) begin
            armed_nxt_s = 1'b1;
        end else begin
            armed_nxt_s = armed_r;
        end

        // start from IDLE clears the sticky error; any other start is a
        // violation, as is an AD block arriving after text has begun.
        if (start && (phase_r == PH_IDLE)) begin
            proto_err_nxt_s = 1'b0;
        end else if (start || order_err_s) begin
            proto_err_nxt_s = 1'b1;
        end else begin
            proto_err_nxt_s = proto_err_r;
        end

        case (phase_r)
            PH_IDLE: begin
                if (start) begin
                    phase_nxt_s = PH_AD;
                    busy_nxt_s  = 1'b1;
                end else begin
                    phase_nxt_s = PH_IDLE;
                end
            end
            PH_AD: begin
                // The first text block ends the AD section, which may be empty.
                if (capture_s && sel_data) begin
                    phase_nxt_s = last_block ? PH_DRAIN : PH_TEXT;
                end else begin
                    phase_nxt_s = PH_AD;
                end
            end
            PH_TEXT: begin
                if (capture_s && sel_data && last_block) begin
                    phase_nxt_s = PH_DRAIN;
                end else begin
                    phase_nxt_s = PH_TEXT;
                end
            end
            PH_DRAIN: begin
                if (out_pop_s && out_head_last_s) begin
                    phase_nxt_s    = PH_IDLE;
                    busy_nxt_s     = 1'b0;
                    finished_nxt_s = 1'b1;
                end else begin
                    phase_nxt_s = PH_DRAIN;
                end
            end
            default: begin
                phase_nxt_s = PH_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_blk_rx.sv
module tb_ascon_blk_rx;
    import ascon_pkg::*;

    localparam int W    = 128;
    localparam int IND  = 2;
    localparam int OUTD = 2;

    logic         clk = 1'b0;
    logic         rstn, start, dinReq, sel_data, last_block, doAck;
    logic         blk_ready, res_last, res_valid;
    logic [W-1:0] Din, res_data;
    logic         dinAck, doReq, busy, finished, proto_err;
    logic         blk_is_text, blk_last, blk_valid, res_ready;
    logic [W-1:0] Dout, blk_data;

    ascon_blk_rx #(.W(W), .IN_DEPTH(IND), .OUT_DEPTH(OUTD)) dut (
        .clk(clk), .rstn(rstn), .start(start), .Din(Din), .dinReq(dinReq),
        .sel_data(sel_data), .last_block(last_block), .dinAck(dinAck),
        .Dout(Dout), .doReq(doReq), .doAck(doAck), .busy(busy),
        .finished(finished), .proto_err(proto_err), .blk_data(blk_data),
        .blk_is_text(blk_is_text), .blk_last(blk_last), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .res_data(res_data), .res_last(res_last),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ack_cnt  = 0;
    int in_pops  = 0;
    int out_pops = 0;
    int ack_mode = 0;   // 0: doAck low, 1: random, 2: high
    bit rnd_ready = 1'b0;

    typedef struct { logic [W-1:0] d; logic t; logic l; } blk_t;
    typedef struct { logic [W-1:0] d; logic l; } res_t;
    blk_t blkq[$];
    res_t outq[$];

    // Reference model state: message phase 0 idle, 1 AD, 2 text, 3 drain.
    int m_phase;
    bit m_armed, m_ack, m_busy, m_fin, m_err;

    task automatic tally(input bit ok, input string name, input string act, input string exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tally(act === exp, name, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tally(act === exp, name, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chki(input string name, input int act, input int exp);
        tally(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_dinAck"}, dinAck, 1'b0);
        chk1({tag, "_doReq"}, doReq, 1'b0);
        chkw({tag, "_Dout"}, Dout, {W{1'b0}});
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_finished"}, finished, 1'b0);
        chk1({tag, "_proto_err"}, proto_err, 1'b0);
        chk1({tag, "_blk_valid"}, blk_valid, 1'b0);
        chk1({tag, "_res_ready"}, res_ready, 1'b1);
    endtask

    // Monitor / scoreboard: compare at the falling edge, then advance the
    // model by the transfers the next rising edge will perform.
    bit   mc_cap, mc_inpop, mc_outpop, mc_poplast, mc_outpush;
    int   mc_ph;
    blk_t mc_b;
    res_t mc_r;
    always @(negedge clk) begin
        if (!rstn) begin
            blkq.delete(); outq.delete();
            m_phase = 0; m_armed = 1'b1; m_ack = 1'b0;
            m_busy = 1'b0; m_fin = 1'b0; m_err = 1'b0;
            chk_reset_outputs("rst");
        end else begin
            chk1("dinAck", dinAck, m_ack);
            chk1("busy", busy, m_busy);
            chk1("finished", finished, m_fin);
            chk1("proto_err", proto_err, m_err);
            chk1("blk_valid", blk_valid, blkq.size() != 0);
            if (blkq.size() != 0) begin
                chkw("blk_data", blk_data, blkq[0].d);
                chk1("blk_is_text", blk_is_text, blkq[0].t);
                chk1("blk_last", blk_last, blkq[0].l);
            end
            chk1("doReq", doReq, outq.size() != 0);
            chk1("res_ready", res_ready, outq.size() < OUTD);
            if (outq.size() != 0) chkw("Dout", Dout, outq[0].d);
            if (dinAck) ack_cnt++;

            mc_ph      = m_phase;
            mc_cap     = dinReq && m_armed && (mc_ph == 1 || mc_ph == 2) && (blkq.size() < IND);
            mc_inpop   = (blkq.size() != 0) && blk_ready;
            mc_outpop  = (outq.size() != 0) && doAck;
            mc_poplast = mc_outpop && outq[0].l;
            mc_outpush = res_valid && (outq.size() < OUTD);
            if (mc_inpop) begin void'(blkq.pop_front()); in_pops++; end
            if (mc_cap) begin
                mc_b.d = Din; mc_b.t = sel_data; mc_b.l = last_block;
                blkq.push_back(mc_b);
            end
            if (mc_outpop) begin void'(outq.pop_front()); out_pops++; end
            if (mc_outpush) begin
                mc_r.d = res_data; mc_r.l = res_last;
                outq.push_back(mc_r);
            end
            m_ack = mc_cap;
            if (mc_cap) m_armed = 1'b0;
            else if (!dinReq) m_armed = 1'b1;
            m_fin = 1'b0;
            if (start) begin
                if (mc_ph == 0) begin m_phase = 1; m_busy = 1'b1; m_err = 1'b0; end
                else m_err = 1'b1;
            end
            if (mc_cap && mc_ph == 1 && sel_data) m_phase = last_block ? 3 : 2;
            if (mc_cap && mc_ph == 2) begin
                if (!sel_data) m_err = 1'b1;
                else if (last_block) m_phase = 3;
            end
            if (mc_ph == 3 && mc_poplast) begin
                m_phase = 0; m_busy = 1'b0; m_fin = 1'b1;
            end
        end
    end

    // Background driver for engine readiness and host result acceptance.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) blk_ready = 1'($urandom_range(0, 1));
            case (ack_mode)
                1: doAck = 1'($urandom_range(0, 1));
                2: doAck = 1'b1;
                default: doAck = 1'b0;
            endcase
        end
    end

    function automatic logic [W-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_ack(input int lim, output bit got);
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (dinAck) got = 1'b1;
        end
    endtask

    task automatic send_block(input logic [W-1:0] d, input logic t, input logic l);
        bit got;
        @(posedge clk); #1;
        Din = d; sel_data = t; last_block = l; dinReq = 1'b1;
        wait_ack(200, got);
        chk1("dinAck_seen", got, 1'b1);
        @(posedge clk); #1 dinReq = 1'b0;
    endtask

    task automatic push_result(input logic [W-1:0] d, input logic l);
        bit got;
        @(posedge clk); #1;
        res_data = d; res_last = l; res_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (res_ready) got = 1'b1;
        end
        chk1("res_accepted", got, 1'b1);
        @(posedge clk); #1 res_valid = 1'b0;
    endtask

    task automatic wait_finished(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (finished) got = 1'b1;
        end
        chk1(name, got, 1'b1);
        @(negedge clk);
        chk1({name, "_busy_low"}, busy, 1'b0);
    endtask

    localparam logic [W-1:0] BLK_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] BLK_PAD = 128'h80000000000000000000000000000000;

    initial begin
        int a0, p0;
        bit got;
        logic [W-1:0] r0, r1, r2;
        rstn = 1'b0; start = 1'b0; dinReq = 1'b0; sel_data = 1'b0;
        last_block = 1'b0; blk_ready = 1'b0; res_valid = 1'b0;
        res_last = 1'b0; Din = {W{1'b0}}; res_data = {W{1'b0}}; doAck = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("init");
        rstn = 1'b1;

        // Host sequence
        blk_ready = 1'b1; ack_mode = 2;
        a0 = ack_cnt; p0 = out_pops;
        pulse_start();
        send_block(BLK_SEQ, 1'b0, 1'b0);
        send_block(BLK_PAD, 1'b0, 1'b1);
        send_block(BLK_SEQ, 1'b1, 1'b0);
        send_block(BLK_PAD, 1'b1, 1'b1);
        chki("t1_acks", ack_cnt - a0, 4);
        push_result(rnd_blk(), 1'b0);
        push_result(rnd_blk(), 1'b1);
        wait_finished("t1_finished");
        chki("t1_pops", out_pops - p0, 2);
        chk1("t1_proto_err", proto_err, 1'b0);

        // Back-pressure from the engine
        blk_ready = 1'b0;
        pulse_start();
        send_block(rnd_blk(), 1'b0, 1'b0);
        send_block(rnd_blk(), 1'b0, 1'b0);
        @(posedge clk); #1;
        Din = rnd_blk(); sel_data = 1'b0; last_block = 1'b1; dinReq = 1'b1;
        a0 = ack_cnt;
        repeat (5) @(negedge clk);
        chki("t2_held_no_ack", ack_cnt - a0, 0);
        @(posedge clk); #1 blk_ready = 1'b1;
        wait_ack(3, got);
        chk1("t2_ack_after_ready", got, 1'b1);
        @(posedge clk); #1 dinReq = 1'b0;
        send_block(rnd_blk(), 1'b1, 1'b1);
        push_result(rnd_blk(), 1'b1);
        wait_finished("t2_finished");

        // Held dinReq gives a single capture
        blk_ready = 1'b0;
        pulse_start();
        @(posedge clk); #1;
        Din = rnd_blk(); sel_data = 1'b0; last_block = 1'b0; dinReq = 1'b1;
        a0 = ack_cnt;
        wait_ack(10, got);
        repeat (4) @(posedge clk);
        #1 dinReq = 1'b0;
        repeat (2) @(negedge clk);
        chki("t3_one_ack", ack_cnt - a0, 1);
        p0 = in_pops;
        @(posedge clk); #1 blk_ready = 1'b1;
        repeat (4) @(negedge clk);
        chki("t3_one_entry", in_pops - p0, 1);
        send_block(rnd_blk(), 1'b1, 1'b1);
        push_result(rnd_blk(), 1'b1);
        wait_finished("t3_finished");

        // Output stall with an empty AD section
        ack_mode = 0;
        pulse_start();
        send_block(rnd_blk(), 1'b1, 1'b1);
        r0 = rnd_blk(); r1 = rnd_blk(); r2 = rnd_blk();
        push_result(r0, 1'b0);
        push_result(r1, 1'b0);
        @(posedge clk); #1;
        res_data = r2; res_last = 1'b1; res_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk1("t4_res_ready_full", res_ready, 1'b0);
        chkw("t4_dout_holds_first", Dout, r0);
        ack_mode = 2;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (res_ready) got = 1'b1;
        end
        chk1("t4_third_accepted", got, 1'b1);
        @(posedge clk); #1 res_valid = 1'b0;
        wait_finished("t4_finished");

        // Protocol errors and stickiness
        pulse_start();
        send_block(rnd_blk(), 1'b0, 1'b0);
        send_block(rnd_blk(), 1'b1, 1'b0);
        send_block(rnd_blk(), 1'b0, 1'b0);
        @(negedge clk);
        chk1("t5_err_ad_after_text", proto_err, 1'b1);
        pulse_start();
        @(negedge clk);
        chk1("t5_err_after_busy_start", proto_err, 1'b1);
        send_block(rnd_blk(), 1'b1, 1'b1);
        push_result(rnd_blk(), 1'b1);
        wait_finished("t5_finished");
        repeat (2) @(negedge clk);
        chk1("t5_err_sticky_idle", proto_err, 1'b1);
        pulse_start();
        @(negedge clk);
        chk1("t5_err_cleared", proto_err, 1'b0);

        // Reset mid-message with one entry in each FIFO
        blk_ready = 1'b0; ack_mode = 0;
        send_block(rnd_blk(), 1'b0, 1'b0);
        push_result(rnd_blk(), 1'b0);
        @(negedge clk);
        chk1("t6_blk_valid_before", blk_valid, 1'b1);
        chk1("t6_doReq_before", doReq, 1'b1);
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("t6");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Randomized messages
        rnd_ready = 1'b1; ack_mode = 1;
        for (int m = 0; m < 8; m++) begin
            int nad, ntx, nres;
            nad  = $urandom_range(0, 3);
            ntx  = $urandom_range(1, 3);
            nres = $urandom_range(1, 3);
            pulse_start();
            for (int i = 0; i < nad; i++) send_block(rnd_blk(), 1'b0, 1'(i == nad - 1));
            for (int i = 0; i < ntx; i++) send_block(rnd_blk(), 1'b1, 1'(i == ntx - 1));
            for (int i = 0; i < nres; i++) push_result(rnd_blk(), 1'(i == nres - 1));
            wait_finished("t7_finished");
            chk1("t7_proto_err", proto_err, 1'b0);
        end
        rnd_ready = 1'b0; ack_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
